lsu_mem_master: RTL and testbench

//  Load/store initiator driving the byte-addressed, little-endian data memory from the core side.

---
 rtl/lsu_mem_master_if.sv | 27 ++
 rtl/lsu_mem_master.sv | 185 ++++++++++++++++++
 tb/tb_lsu_mem_master.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_master_if.sv
// Bus bundle for the load/store initiator: core request/response channel plus
// the word-wide data memory port.
interface lsu_mem_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_mem_master.sv
// Load/store initiator: one RV32I load/store per handshake against a word-wide,
// little-endian memory; sub-word stores are done as read-modify-write.
module lsu_mem_master #(
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_0400
) (
    input  logic             clk,
    input  logic             rst,
    lsu_mem_master_if.master bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        RMW_RD = 3'd2,
        WR     = 3'd3,
        RESP   = 3'd4
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    state_t      state_r;
    state_t      state_s;
    logic        we_r;
    logic [2:0]  funct3_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [31:0] rd_word_r;
    logic        resp_valid_r;
    logic        resp_err_r;
    logic [31:0] resp_rdata_r;
    logic        req_err_s;
    logic [31:0] word_addr_s;

    // Illegal encoding, misalignment for the access size, or out-of-range address.
    function automatic logic req_error(input logic we, input logic [2:0] f3,
                                       input logic [31:0] addr);
        logic e;
        case (f3)
            F3_B:    e = 1'b0;
            F3_H:    e = addr[0];
            F3_W:    e = (addr[1:0] != 2'b00);
            F3_BU:   e = we;
            F3_HU:   e = we | addr[0];
            default: e = 1'b1;
        endcase
        return e | (addr >= ADDR_LIMIT);
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f3,
                                                input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(word >> {lane, 3'b000});
        h = 16'(word >> {lane[1], 4'b0000});
        case (f3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_W:    r = word;
            F3_BU:   r = {24'h00_0000, b};
            F3_HU:   r = {16'h0000, h};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Untouched lanes keep the value captured during the read phase.
    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wdata,
                                                input logic [2:0] f3, input logic [1:0] lane);
        logic [31:0] mask;
        case (f3)
            F3_B:    mask = 32'h0000_00FF << {lane, 3'b000};
            F3_H:    mask = 32'h0000_FFFF << {lane[1], 4'b0000};
            default: mask = 32'hFFFF_FFFF;
        endcase
        return (old & ~mask) | ((wdata << {lane, 3'b000}) & mask);
    endfunction

    assign req_err_s       = req_error(bus.req_we, bus.req_funct3, bus.req_addr);
    assign word_addr_s     = {addr_r[31:2], 2'b00};
    assign bus.resp_valid  = resp_valid_r;
    assign bus.resp_err    = resp_err_r;
    assign bus.resp_rdata  = resp_rdata_r;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state plus handshake and memory-port outputs; reset gates ready and write.
    always_comb begin
        state_s       = state_r;
        bus.req_ready = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = 32'h0000_0000;
        bus.mem_wdata = 32'h0000_0000;
        if (!rst) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    bus.req_ready = 1'b1;
                    if (bus.req_valid) begin
                        if (req_err_s) begin
                            state_s = RESP;
                        end else if (!bus.req_we) begin
                            state_s = RD;
                        end else if (bus.req_funct3 == F3_W) begin
                            state_s = WR;
                        end else begin
                            state_s = RMW_RD;
                        end
                    end else begin
                        state_s = IDLE;
                    end
                end
                RD: begin
                    state_s      = RESP;
                    bus.mem_addr = word_addr_s;
                end
                RMW_RD: begin
                    state_s      = WR;
                    bus.mem_addr = word_addr_s;
                end
                WR: begin
                    state_s       = RESP;
                    bus.mem_we    = 1'b1;
                    bus.mem_addr  = word_addr_s;
                    bus.mem_wdata = (funct3_r == F3_W) ? wdata_r
                                    : store_merge(rd_word_r, wdata_r, funct3_r, addr_r[1:0]);
                end
                RESP:    state_s = IDLE;
                default: state_s = IDLE;
            endcase
        end
    end

    // Request latch, read capture and registered response (valid only in RESP).
    always_ff @(posedge clk) begin
        if (!rst) begin
            we_r         <= 1'b0;
            funct3_r     <= 3'b000;
            addr_r       <= 32'h0000_0000;
            wdata_r      <= 32'h0000_0000;
            rd_word_r    <= 32'h0000_0000;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
        end else begin
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
            case (state_r)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_r         <= bus.req_we;
                        funct3_r     <= bus.req_funct3;
                        addr_r       <= bus.req_addr;
                        wdata_r      <= bus.req_wdata;
                        resp_valid_r <= req_err_s;
                        resp_err_r   <= req_err_s;
                    end else begin
                        we_r <= we_r;
                    end
                end
                RD: begin
                    resp_valid_r <= 1'b1;
                    resp_rdata_r <= load_extend(bus.mem_rdata, funct3_r, addr_r[1:0]);
                end
                RMW_RD:  rd_word_r    <= bus.mem_rdata;
                WR:      resp_valid_r <= 1'b1;
                default: we_r         <= we_r;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed and randomized bench for lsu_mem_master against a byte-array memory model.
module tb_lsu_mem_master;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    logic [31:0] mem_words [0:255];
    logic [7:0]  ref_bytes [0:1023];
    logic [2:0]  legal_f3  [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    lsu_mem_master_if bus ();

    lsu_mem_master #(.ADDR_LIMIT(32'h0000_0400)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.mem_rdata = mem_words[bus.mem_addr[9:2]];

    // Word memory behind the DUT: random initial contents, writes on the clock edge.
    initial begin
        for (int i = 0; i < 256; i++) mem_words[i] = $urandom;
        forever begin
            @(posedge clk);
            if (bus.mem_we) mem_words[bus.mem_addr[9:2]] <= bus.mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        int n;
        n = 1 << f3[1:0];
        if (f3 == 3'd3 || f3 >= 3'd6) return 1'b1;
        if (we && f3[2]) return 1'b1;
        if (addr >= 32'h400) return 1'b1;
        return (addr % n) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
        int n;
        logic [31:0] v;
        n = 1 << f3[1:0];
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_bytes[addr + i]) << (8 * i));
        if (!f3[2] && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] aligned);
        return {ref_bytes[aligned + 3], ref_bytes[aligned + 2], ref_bytes[aligned + 1], ref_bytes[aligned]};
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        n = 1 << f3[1:0];
        for (int i = 0; i < n; i++) ref_bytes[addr + i] = 8'(wdata >> (8 * i));
    endtask

    task automatic noise_inputs();
        bus.req_we     = 1'($urandom_range(0, 1));
        bus.req_funct3 = 3'($urandom_range(0, 7));
        bus.req_addr   = 32'($urandom_range(0, 1023));
        bus.req_wdata  = $urandom;
    endtask

    // One request from IDLE through RESP and back to IDLE, checked cycle by cycle.
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input bit noise, output logic [31:0] got);
        bit          err;
        int          lat;
        logic [31:0] exp_rd;
        logic [31:0] exp_ww;
        logic [31:0] aligned;
        err     = model_err(we, f3, addr);
        aligned = addr & 32'hFFFF_FFFC;
        exp_rd  = 32'h0;
        exp_ww  = 32'h0;
        if (err) begin
            lat = 1;
        end else if (!we) begin
            lat    = 2;
            exp_rd = model_load(f3, addr);
        end else begin
            lat = (f3 == 3'b010) ? 2 : 3;
            model_store(f3, addr, wdata);
            exp_ww = model_word(aligned);
        end
        got = 32'h0;
        check("ready_idle", 32'(bus.req_ready), 32'h1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(posedge clk); #1;
        if (noise) noise_inputs();
        else bus.req_valid = 1'b0;
        for (int c = 1; c <= lat; c++) begin
            check("busy_ready", 32'(bus.req_ready), 32'h0);
            check("resp_valid", 32'(bus.resp_valid), 32'(c == lat));
            check("mem_we", 32'(bus.mem_we), 32'(we && !err && c == lat - 1));
            if (!err && c < lat) check("mem_addr", bus.mem_addr, aligned);
            if (we && !err && c == lat - 1) check("mem_wdata", bus.mem_wdata, exp_ww);
            if (c == lat) begin
                check("resp_err", 32'(bus.resp_err), 32'(err));
                check("resp_rdata", bus.resp_rdata, exp_rd);
                got           = bus.resp_rdata;
                bus.req_valid = 1'b0;
            end else if (noise) begin
                noise_inputs();
            end
            @(posedge clk); #1;
        end
        check("idle_valid", 32'(bus.resp_valid), 32'h0);
        check("idle_rdata", bus.resp_rdata, 32'h0);
        check("idle_err", 32'(bus.resp_err), 32'h0);
        check("idle_addr", bus.mem_addr, 32'h0);
        check("idle_ready", 32'(bus.req_ready), 32'h1);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] r_addr;
        logic [2:0]  r_f3;
        logic        r_we;
        int          sel;

        rst            = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = $urandom;

        repeat (3) begin
            @(posedge clk); #1;
            check("rst_ready", 32'(bus.req_ready), 32'h0);
            check("rst_mem_we", 32'(bus.mem_we), 32'h0);
            check("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
            check("rst_resp_err", 32'(bus.resp_err), 32'h0);
            check("rst_resp_rdata", bus.resp_rdata, 32'h0);
        end
        for (int i = 0; i < 256; i++)
            for (int b = 0; b < 4; b++) ref_bytes[4 * i + b] = mem_words[i][8 * b +: 8];
        bus.req_valid = 1'b0;
        rst           = 1'b1;
        @(posedge clk); #1;
        check("rel_ready", 32'(bus.req_ready), 32'h1);
        check("rel_mem_addr", bus.mem_addr, 32'h0);
        check("rel_mem_wdata", bus.mem_wdata, 32'h0);

        // Word store, byte read-modify-write, then readback.
        run_req(1'b1, 3'b010, 32'h0C, 32'hDEAD_BEEF, 1'b0, got);
        run_req(1'b1, 3'b000, 32'h0D, 32'h0000_00A5, 1'b0, got);
        run_req(1'b0, 3'b010, 32'h0C, 32'h0, 1'b0, got);
        check("t3_word", got, 32'hDEAD_A5EF);

        // Lane extraction with sign and zero extension.
        run_req(1'b1, 3'b010, 32'h0C, 32'h8000_1234, 1'b0, got);
        run_req(1'b0, 3'b000, 32'h0F, 32'h0, 1'b0, got);
        check("t4_lb", got, 32'hFFFF_FF80);
        run_req(1'b0, 3'b100, 32'h0F, 32'h0, 1'b1, got);
        check("t4_lbu", got, 32'h0000_0080);
        run_req(1'b0, 3'b001, 32'h0E, 32'h0, 1'b0, got);
        check("t4_lh", got, 32'hFFFF_8000);
        run_req(1'b0, 3'b101, 32'h0C, 32'h0, 1'b1, got);
        check("t4_lhu", got, 32'h0000_1234);

        // Error cases and address-limit boundaries.
        run_req(1'b0, 3'b010, 32'h06, 32'h0, 1'b0, got);
        run_req(1'b1, 3'b010, 32'h400, $urandom, 1'b0, got);
        run_req(1'b1, 3'b100, 32'h10, $urandom, 1'b0, got);
        run_req(1'b0, 3'b011, 32'h10, 32'h0, 1'b0, got);
        run_req(1'b0, 3'b111, 32'h10, 32'h0, 1'b0, got);
        run_req(1'b1, 3'b001, 32'h13, $urandom, 1'b0, got);
        run_req(1'b1, 3'b010, 32'h3FC, 32'h1234_5678, 1'b0, got);
        run_req(1'b0, 3'b010, 32'h3FC, 32'h0, 1'b0, got);
        check("lim_lw", got, 32'h1234_5678);
        run_req(1'b0, 3'b000, 32'h3FF, 32'h0, 1'b0, got);
        run_req(1'b0, 3'b000, 32'h400, 32'h0, 1'b0, got);

        // Reset during the read phase of a half store: no write, no response.
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b001;
        bus.req_addr   = 32'h20;
        bus.req_wdata  = $urandom;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("t6_rmw_we", 32'(bus.mem_we), 32'h0);
        check("t6_rmw_addr", bus.mem_addr, 32'h20);
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            check("t6_valid", 32'(bus.resp_valid), 32'h0);
            check("t6_ready", 32'(bus.req_ready), 32'h0);
            check("t6_we", 32'(bus.mem_we), 32'h0);
        end
        rst = 1'b1;
        #1;
        check("t6_ready_rel", 32'(bus.req_ready), 32'h1);
        @(posedge clk); #1;
        check("t6_no_resp", 32'(bus.resp_valid), 32'h0);
        check("t6_word", mem_words[8], model_word(32'h20));
        run_req(1'b0, 3'b010, 32'h20, 32'h0, 1'b0, got);

        // Reset while the word write is on the bus must suppress it.
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h24;
        bus.req_wdata  = ~model_word(32'h24);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("wr_we", 32'(bus.mem_we), 32'h1);
        rst = 1'b0;
        #1;
        check("wr_rst_we", 32'(bus.mem_we), 32'h0);
        @(posedge clk); #1;
        check("wr_no_resp", 32'(bus.resp_valid), 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        run_req(1'b0, 3'b010, 32'h24, 32'h0, 1'b0, got);

        // Randomized mix, biased toward legal aligned accesses.
        for (int k = 0; k < 300; k++) begin
            sel    = $urandom_range(0, 9);
            r_we   = 1'($urandom_range(0, 1));
            r_f3   = 3'($urandom_range(0, 7));
            r_addr = 32'($urandom_range(0, 1023));
            if (sel == 0) begin
                r_addr = 32'h400 + 32'($urandom_range(0, 15));
            end else if (sel == 1) begin
                r_addr = $urandom;
            end else if (sel < 6) begin
                r_f3        = legal_f3[$urandom_range(0, 4)];
                r_addr[1:0] = 2'b00;
            end else if (sel < 9) begin
                r_f3 = legal_f3[$urandom_range(0, 4)];
            end
            run_req(r_we, r_f3, r_addr, $urandom, 1'($urandom_range(0, 1)), got);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
